// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: requester ownership, FSM states
// and default bus widths.
package dmem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } owner_e;

  typedef enum logic {
    ST_SHARED = 1'b0,
    ST_LOADER = 1'b1
  } dmem_state_e;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_CPU) ? OWN_LD : OWN_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the load-mode select and the single-port RAM
// port. The arbiter uses the slave modport, the environment the master modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  // Handshake: a requester raises *_req with we/addr/wdata; the request is
  // accepted in exactly the cycles where *_gnt is high (combinational, same
  // cycle). A read answers with a one-cycle *_rvalid the following cycle; a
  // misaligned access answers with a one-cycle *_err the following cycle.
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic              c_err;
  logic [DATA_W-1:0] c_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic              l_err;
  logic [DATA_W-1:0] l_rdata;

  logic              load_mode;

  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_err, c_rdata,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_err, l_rdata,
    input  load_mode,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_err, c_rdata,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_err, l_rdata,
    output load_mode,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / loader) arbiter in front of a single-port RAM with
// one-cycle read latency; round-robin when shared, loader-exclusive in load mode.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic           clock,
  input  logic           reset_n,
  dmem_arbiter_if.slave  bus,
  output dmem_state_e    dbg_state_o,
  output owner_e         dbg_ptr_o
);

  dmem_state_e state_q, state_d;
  owner_e      ptr_q, ptr_d;
  logic        tag_vld_q, tag_vld_d;
  owner_e      tag_own_q, tag_own_d;
  logic [1:0]  err_q, err_d;

  owner_e            eff_ptr;
  logic              c_pick, l_pick, gnt_any, g_we, g_mis;
  owner_e            g_own;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  always_comb begin
    state_d   = bus.load_mode ? ST_LOADER : ST_SHARED;
    // The first shared cycle after load mode already favours the CPU.
    eff_ptr   = (state_q == ST_LOADER) ? OWN_CPU : ptr_q;
    c_pick    = 1'b0;
    l_pick    = 1'b0;
    if (reset_n) begin
      if (bus.load_mode) begin
        l_pick = bus.l_req;
      end else if (bus.c_req && bus.l_req) begin
        c_pick = (eff_ptr == OWN_CPU);
        l_pick = (eff_ptr == OWN_LD);
      end else begin
        c_pick = bus.c_req;
        l_pick = bus.l_req;
      end
    end

    gnt_any = c_pick || l_pick;
    g_own   = l_pick ? OWN_LD : OWN_CPU;
    g_we    = l_pick ? bus.l_we    : bus.c_we;
    g_addr  = l_pick ? bus.l_addr  : bus.c_addr;
    g_wdata = l_pick ? bus.l_wdata : bus.c_wdata;
    g_mis   = (g_addr[1:0] != 2'b00);

    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = other_owner(g_own);
    end else if (state_q == ST_LOADER && state_d == ST_SHARED) begin
      ptr_d = OWN_CPU;
    end

    tag_vld_d = gnt_any && !g_we && !g_mis;
    tag_own_d = g_own;
    err_d     = {l_pick && g_mis, c_pick && g_mis};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_SHARED;
      ptr_q     <= OWN_CPU;
      tag_vld_q <= 1'b0;
      tag_own_q <= OWN_CPU;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
      err_q     <= err_d;
    end
  end

  // Misaligned accesses are granted but never reach the RAM.
  assign bus.mem_we    = gnt_any && g_we && !g_mis;
  assign bus.mem_addr  = gnt_any ? g_addr[ADDR_W-1:2] : '0;
  assign bus.mem_wdata = gnt_any ? g_wdata : '0;

  assign bus.c_gnt    = c_pick;
  assign bus.l_gnt    = l_pick;
  assign bus.c_rvalid = reset_n && tag_vld_q && (tag_own_q == OWN_CPU);
  assign bus.l_rvalid = reset_n && tag_vld_q && (tag_own_q == OWN_LD);
  assign bus.c_rdata  = bus.c_rvalid ? bus.mem_rdata : '0;
  assign bus.l_rdata  = bus.l_rvalid ? bus.mem_rdata : '0;
  assign bus.c_err    = reset_n && err_q[0];
  assign bus.l_err    = reset_n && err_q[1];

  assign dbg_state_o = state_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model with its own memory image.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  dmem_state_e dbg_state;
  owner_e      dbg_ptr;

  dmem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_ptr_o   (dbg_ptr)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- RAM stand-in (1-cycle read) ----------------
  logic [31:0] ram    [16384];
  bit          ram_wr [16384];
  logic [31:0] ram_rd_q;

  function automatic logic [31:0] init_pat(input logic [13:0] a);
    return {2'b10, a, ~a, 2'b01};
  endfunction

  function automatic logic [31:0] ram_peek(input logic [13:0] a);
    return ram_wr[a] ? ram[a] : init_pat(a);
  endfunction

  always @(posedge clock) begin
    ram_rd_q <= ram_peek(bus.mem_addr);
    if (bus.mem_we) begin
      ram[bus.mem_addr]    <= bus.mem_wdata;
      ram_wr[bus.mem_addr] <= 1'b1;
    end
  end
  assign bus.mem_rdata = ram_rd_q;

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_mem [16384];
  bit          p_rv = 1'b0;
  bit          p_own = 1'b0;
  bit          p_err_c = 1'b0;
  bit          p_err_l = 1'b0;
  bit          m_cpu_first = 1'b1;
  bit          m_prev_lm = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%08h exp=0x%08h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver + model, one clock per call ----------------
  task automatic do_cycle(input logic rst_n, input logic lm,
                          input logic cr, input logic cw, input logic [15:0] ca, input logic [31:0] cd,
                          input logic lr, input logic lw, input logic [15:0] la, input logic [31:0] ldat);
    logic        eg_c, eg_l, first, mis, we, gnt, rv_c, rv_l;
    logic [15:0] a;
    logic [31:0] wd, d;
    logic [13:0] wa;
    @(negedge clock);
    reset_n       = rst_n;
    bus.load_mode = lm;
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.l_req = lr; bus.l_we = lw; bus.l_addr = la; bus.l_wdata = ldat;
    #1;
    eg_c = 1'b0;
    eg_l = 1'b0;
    if (rst_n) begin
      if (lm) begin
        eg_l = lr;
      end else if (cr && lr) begin
        first = m_prev_lm ? 1'b1 : m_cpu_first;
        eg_c  = first;
        eg_l  = !first;
      end else begin
        eg_c = cr;
        eg_l = lr;
      end
    end
    gnt = eg_c || eg_l;
    check("c_gnt", 32'(bus.c_gnt), 32'(eg_c));
    check("l_gnt", 32'(bus.l_gnt), 32'(eg_l));

    a   = eg_l ? la : ca;
    we  = eg_l ? lw : cw;
    wd  = eg_l ? ldat : cd;
    mis = (a[1:0] != 2'b00);
    wa  = a[15:2];
    if (gnt) begin
      check("mem_we", 32'(bus.mem_we), 32'(we && !mis));
      check("mem_addr", 32'(bus.mem_addr), 32'(wa));
      if (we && !mis) check("mem_wdata", bus.mem_wdata, wd);
    end else begin
      check("mem_we_idle", 32'(bus.mem_we), 32'd0);
    end

    d = 32'd0;
    if (p_rv && exp_q.size() > 0) d = exp_q.pop_front();
    rv_c = rst_n && p_rv && !p_own;
    rv_l = rst_n && p_rv && p_own;
    check("c_rvalid", 32'(bus.c_rvalid), 32'(rv_c));
    check("l_rvalid", 32'(bus.l_rvalid), 32'(rv_l));
    check("c_rdata", bus.c_rdata, rv_c ? d : 32'd0);
    check("l_rdata", bus.l_rdata, rv_l ? d : 32'd0);
    check("c_err", 32'(bus.c_err), 32'(rst_n && p_err_c));
    check("l_err", 32'(bus.l_err), 32'(rst_n && p_err_l));

    if (!rst_n) begin
      p_rv = 1'b0; p_err_c = 1'b0; p_err_l = 1'b0;
      m_cpu_first = 1'b1; m_prev_lm = 1'b0;
      exp_q.delete();
    end else begin
      p_rv  = gnt && !we && !mis;
      p_own = eg_l;
      if (p_rv) exp_q.push_back(exp_mem[wa]);
      p_err_c = eg_c && mis;
      p_err_l = eg_l && mis;
      if (gnt && we && !mis) exp_mem[wa] = wd;
      if (gnt) m_cpu_first = eg_l;
      else if (m_prev_lm && !lm) m_cpu_first = 1'b1;
      m_prev_lm = lm;
    end
  endtask

  task automatic idle(input logic lm);
    do_cycle(1'b1, lm, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] base;
    base = 16'(($urandom_range(0, 15)) * 4);
    if ($urandom_range(0, 4) == 0) base = base + 16'($urandom_range(1, 3));
    return base;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic lm_r;
    for (int i = 0; i < 16384; i++) exp_mem[i] = init_pat(14'(i));
    bus.load_mode = 1'b0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = '0; bus.l_wdata = '0;

    // reset with traffic present: everything held low
    do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 32'h1111, 1'b1, 1'b0, 16'h0008, 32'h0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 32'h0, 1'b1, 1'b0, 16'h0008, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_SHARED));
    check("rst_ptr", 32'(dbg_ptr), 32'(OWN_CPU));

    // CPU-only read of 0x0010
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    check("cpu_rd_gnt", 32'(bus.c_gnt), 32'd1);
    check("cpu_rd_addr", 32'(bus.mem_addr), 32'h0004);
    idle(1'b0);
    check("cpu_rd_rvalid", 32'(bus.c_rvalid), 32'd1);
    check("cpu_rd_data", bus.c_rdata, init_pat(14'h0004));

    // contention from a CPU-first pointer: C, L, C, L
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'(32 + 4 * i), 32'h0, 1'b1, 1'b0, 16'(64 + 4 * i), 32'h0);
      check("rr_cpu", 32'(bus.c_gnt), 32'(i % 2 == 0));
      check("rr_ld", 32'(bus.l_gnt), 32'(i % 2 == 1));
    end

    // load mode: loader exclusive, then first tie back to CPU
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b1, 1'b0, 16'(16'h0080 + 4 * i), 32'h0);
      check("lm_l_gnt", 32'(bus.l_gnt), 32'd1);
      check("lm_c_gnt", 32'(bus.c_gnt), 32'd0);
    end
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b1, 1'b0, 16'h0080, 32'h0);
    check("lm_exit_tie", 32'(bus.c_gnt), 32'd1);
    idle(1'b0);

    // misaligned CPU write
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'h0006, 32'h12345678, 1'b0, 1'b0, 16'h0, 32'h0);
    check("mis_gnt", 32'(bus.c_gnt), 32'd1);
    check("mis_mem_we", 32'(bus.mem_we), 32'd0);
    idle(1'b0);
    check("mis_err", 32'(bus.c_err), 32'd1);
    idle(1'b0);
    check("mis_err_drop", 32'(bus.c_err), 32'd0);
    check("mis_ram", ram_peek(14'd1), init_pat(14'd1));

    // loader write then CPU read-back
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0100, 32'hDEADBEEF);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    idle(1'b0);
    check("wb_rdata", bus.c_rdata, 32'hDEADBEEF);

    // reset right after a granted read drops the response
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0);
    check("rst_rd_rvalid", 32'(bus.c_rvalid), 32'd0);
    idle(1'b0);
    check("rst_rd_ptr", 32'(dbg_ptr), 32'(OWN_CPU));
    check("rst_rd_rvalid2", 32'(bus.c_rvalid), 32'd0);

    // random traffic
    lm_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) lm_r = ~lm_r;
      do_cycle(1'($urandom_range(0, 59) != 0), lm_r,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rand_addr(), $urandom,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), rand_addr(), $urandom);
    end
    idle(1'b0);
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
